pad_gpio_ctrl: RTL

//  Core-side controller for the bidirectional GPIO pad bank, sitting between the
//  gf180mcu bi_24t pad instances and the core logic. It synchronises and debounces
//  pad inputs and latches rising-edge events into an interrupt. It also holds the
//  per-pad drive configuration (A/OE/IE/PU/PD/CS) written through a simple register port.

---
 rtl/pad_gpio_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pad_gpio_ctrl.sv
// Core-side controller for a bidirectional GPIO pad bank: pad input synchronisation,
// debouncing, rising-edge event/interrupt latching and per-pad drive configuration registers.
module pad_gpio_ctrl #(
  parameter int NUM_PADS        = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PADS-1:0] pad_y,
  output logic [NUM_PADS-1:0] pad_a,
  output logic [NUM_PADS-1:0] pad_oe,
  output logic [NUM_PADS-1:0] pad_ie,
  output logic [NUM_PADS-1:0] pad_pu,
  output logic [NUM_PADS-1:0] pad_pd,
  output logic [NUM_PADS-1:0] pad_cs,
  output logic [NUM_PADS-1:0] pad_sl,
  input  logic                reg_wr,
  input  logic                reg_rd,
  input  logic [3:0]          reg_addr,
  input  logic [NUM_PADS-1:0] reg_wdata,
  output logic [NUM_PADS-1:0] reg_rdata,
  output logic                reg_rvalid,
  output logic [NUM_PADS-1:0] in_filtered,
  output logic                irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] A_OUT    = 4'd0;
  localparam logic [3:0] A_OE     = 4'd1;
  localparam logic [3:0] A_IE     = 4'd2;
  localparam logic [3:0] A_PU     = 4'd3;
  localparam logic [3:0] A_PD     = 4'd4;
  localparam logic [3:0] A_CS     = 4'd5;
  localparam logic [3:0] A_IRQ_EN = 4'd6;
  localparam logic [3:0] A_EVENT  = 4'd7;
  localparam logic [3:0] A_IN     = 4'd8;

  logic [NUM_PADS-1:0] out_q, oe_q, ie_q, pu_q, pd_q, cs_q, irq_en_q, event_q;
  logic [NUM_PADS-1:0] filt_q, filt_d, rise, w1c, s_p, rd_mux, rdata_p1;
  logic [NUM_PADS-1:0] sync_p [SYNC_STAGES];
  logic [CNT_W-1:0]    cnt_q  [NUM_PADS];
  logic [CNT_W-1:0]    cnt_d  [NUM_PADS];
  logic                irq_q, vld_p1;

  // Counter never exceeds the terminal count, so it cannot wrap on long disagreements.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Synchroniser chain: stage 0 samples the asynchronous pad, last stage feeds the debouncer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
    end else begin
      sync_p[0] <= pad_y;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
    end
  end

  assign s_p = sync_p[SYNC_STAGES-1];

  // Debounce: filtered value follows s only after DEBOUNCE_CYCLES consecutive disagreements
  always_comb begin
    filt_d = filt_q;
    rise   = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      cnt_d[i] = '0;
      if (s_p[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          filt_d[i] = s_p[i];
          rise[i]   = s_p[i];
        end else begin
          cnt_d[i] = sat_inc(cnt_q[i]);
        end
      end
    end
  end

  assign w1c = (reg_wr && (reg_addr == A_EVENT)) ? reg_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      oe_q     <= '0;
      ie_q     <= '1;
      pu_q     <= '0;
      pd_q     <= '0;
      cs_q     <= '0;
      irq_en_q <= '0;
      event_q  <= '0;
      filt_q   <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NUM_PADS; i++) cnt_q[i] <= '0;
    end else begin
      if (reg_wr) begin
        case (reg_addr)
          A_OUT:    out_q    <= reg_wdata;
          A_OE:     oe_q     <= reg_wdata;
          A_IE:     ie_q     <= reg_wdata;
          A_PU:     pu_q     <= reg_wdata;
          A_PD:     pd_q     <= reg_wdata;
          A_CS:     cs_q     <= reg_wdata;
          A_IRQ_EN: irq_en_q <= reg_wdata;
          default:  ;
        endcase
      end
      // A new rising edge overrides a simultaneous clear of the same bit
      event_q <= (event_q & ~w1c) | rise;
      filt_q  <= filt_d;
      irq_q   <= |(event_q & irq_en_q);
      for (int i = 0; i < NUM_PADS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      A_OUT:    rd_mux = out_q;
      A_OE:     rd_mux = oe_q;
      A_IE:     rd_mux = ie_q;
      A_PU:     rd_mux = pu_q;
      A_PD:     rd_mux = pd_q;
      A_CS:     rd_mux = cs_q;
      A_IRQ_EN: rd_mux = irq_en_q;
      A_EVENT:  rd_mux = event_q;
      A_IN:     rd_mux = filt_q;
      default:  rd_mux = '0;
    endcase
  end

  // Read stage p1: data captured from pre-write register state, held until the next read
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= reg_rd;
      if (reg_rd) rdata_p1 <= rd_mux;
    end
  end

  assign pad_a       = out_q;
  assign pad_oe      = oe_q;
  assign pad_ie      = ie_q;
  assign pad_pu      = pu_q;
  assign pad_pd      = pd_q & ~pu_q;
  assign pad_cs      = cs_q;
  assign pad_sl      = '0;
  assign reg_rdata   = rdata_p1;
  assign reg_rvalid  = vld_p1;
  assign in_filtered = filt_q;
  assign irq         = irq_q;

endmodule
